// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: 512-bit beats become banked write strobes one cycle after acceptance;
// read side issues one rd_conf per 3x3 tile and holds each tile on tile_valid until tile_ready.
module weight_buffer_ctrl #(
  parameter int ADDR_LEN    = 16,
  parameter int BUFFER_NUM  = 32,
  parameter int GROUPS      = BUFFER_NUM / 8,
  parameter int CNT_LEN     = 16,
  parameter int TILE_STRIDE = 9,
  parameter int KER_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic [ADDR_LEN-1:0]   ld_base,
  input  logic [CNT_LEN-1:0]    ld_beats,
  input  logic [511:0]          s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic [511:0]          data_wr,
  output logic [ADDR_LEN-1:0]   wr_addr,
  output logic [BUFFER_NUM-1:0] wr_en,
  input  logic                  rd_start,
  input  logic [ADDR_LEN-1:0]   rd_base,
  input  logic [CNT_LEN-1:0]    rd_tiles,
  output logic                  rd_conf,
  output logic [ADDR_LEN-1:0]   st_rd_addr,
  input  logic                  ker_en,
  output logic                  tile_valid,
  input  logic                  tile_ready,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  err_timeout
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int TW = $clog2(KER_TIMEOUT + 1);
  localparam logic [CNT_LEN-1:0]    CNT_ONE   = CNT_LEN'(1);
  localparam logic [ADDR_LEN-1:0]   ADDR_ONE  = ADDR_LEN'(1);
  localparam logic [ADDR_LEN-1:0]   STRIDE    = ADDR_LEN'(TILE_STRIDE);
  localparam logic [GW-1:0]         GRP_ONE   = GW'(1);
  localparam logic [GW-1:0]         GRP_LAST  = GW'(GROUPS - 1);
  localparam logic [TW-1:0]         TCNT_ONE  = TW'(1);
  localparam logic [TW-1:0]         TCNT_LAST = TW'(KER_TIMEOUT - 1);
  localparam logic [BUFFER_NUM-1:0] GRP_MASK  = BUFFER_NUM'(8'hFF);

  typedef enum logic {L_IDLE, L_RUN} l_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CONF, R_WAIT, R_HOLD} r_state_t;

  l_state_t              l_state;
  logic [ADDR_LEN-1:0]   ld_base_q;
  logic [ADDR_LEN-1:0]   row;
  logic [CNT_LEN-1:0]    beats_q;
  logic [CNT_LEN-1:0]    beat_cnt;
  logic [GW-1:0]         grp;
  logic [BUFFER_NUM-1:0] wr_en_q;
  logic                  beat_acc;

  r_state_t              r_state;
  logic [CNT_LEN-1:0]    tiles_q;
  logic [CNT_LEN-1:0]    tile_n;
  logic [TW-1:0]         tcnt;

  assign s_ready  = (l_state == L_RUN);
  assign ld_busy  = (l_state == L_RUN);
  assign beat_acc = s_valid && s_ready;
  // The strobe register is masked during the reset cycle so no bank is written while rst is high.
  assign wr_en    = rst ? '0 : wr_en_q;
  assign rd_busy  = (r_state != R_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      l_state   <= L_IDLE;
      ld_base_q <= '0;
      beats_q   <= '0;
      beat_cnt  <= '0;
      row       <= '0;
      grp       <= '0;
      wr_en_q   <= '0;
      data_wr   <= '0;
      wr_addr   <= '0;
      ld_done   <= 1'b0;
    end else begin
      wr_en_q <= '0;
      ld_done <= 1'b0;
      case (l_state)
        L_IDLE: begin
          if (ld_start) begin
            ld_base_q <= ld_base;
            beats_q   <= ld_beats;
            beat_cnt  <= '0;
            row       <= '0;
            grp       <= '0;
            if (ld_beats == '0) ld_done <= 1'b1;
            else                l_state <= L_RUN;
          end
        end
        L_RUN: begin
          if (beat_acc) begin
            data_wr  <= s_data;
            wr_addr  <= ld_base_q + row;
            wr_en_q  <= GRP_MASK << {grp, 3'b000};
            beat_cnt <= beat_cnt + CNT_ONE;
            if (grp == GRP_LAST) begin
              grp <= '0;
              row <= row + ADDR_ONE;
            end else begin
              grp <= grp + GRP_ONE;
            end
            if (beat_cnt == beats_q - CNT_ONE) begin
              l_state <= L_IDLE;
              ld_done <= 1'b1;
            end
          end
        end
        default: l_state <= L_IDLE;
      endcase
    end
  end

  // tcnt counts every cycle since rd_conf, so err_timeout rises exactly KER_TIMEOUT cycles after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      tiles_q     <= '0;
      tile_n      <= '0;
      tcnt        <= '0;
      rd_conf     <= 1'b0;
      st_rd_addr  <= '0;
      tile_valid  <= 1'b0;
      rd_done     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      rd_conf <= 1'b0;
      rd_done <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rd_start) begin
            tiles_q <= rd_tiles;
            tile_n  <= '0;
            if (rd_tiles == '0) begin
              rd_done <= 1'b1;
            end else begin
              r_state    <= R_CONF;
              rd_conf    <= 1'b1;
              st_rd_addr <= rd_base;
              tcnt       <= '0;
            end
          end
        end
        R_CONF: begin
          tcnt    <= tcnt + TCNT_ONE;
          r_state <= R_WAIT;
        end
        R_WAIT: begin
          if (ker_en) begin
            r_state    <= R_HOLD;
            tile_valid <= 1'b1;
          end else if (tcnt == TCNT_LAST) begin
            err_timeout <= 1'b1;
            rd_done     <= 1'b1;
            r_state     <= R_IDLE;
          end else begin
            tcnt <= tcnt + TCNT_ONE;
          end
        end
        R_HOLD: begin
          // rd_conf is only re-issued after tile_valid drops, so ker_out is never overwritten mid-hold.
          if (tile_ready) begin
            tile_valid <= 1'b0;
            tile_n     <= tile_n + CNT_ONE;
            if (tile_n == tiles_q - CNT_ONE) begin
              rd_done <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_state    <= R_CONF;
              rd_conf    <= 1'b1;
              st_rd_addr <= st_rd_addr + STRIDE;
              tcnt       <= '0;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
- Sequencer for the weight buffer. Owns both of its ports.
- Load side: converts a 512-bit weight stream into banked write strobes (data_wr/wr_addr/wr_en).
- Read side: issues rd_conf/st_rd_addr per kernel tile, waits for ker_en, and hands each tile to the PE mesh with a valid/ready handshake.
- Sits between the DMA stream and the weight buffer, under the layer scheduler.

Parameters:
- ADDR_LEN, 16, buffer word address width.
- BUFFER_NUM, 32, number of banks. Must be a multiple of 8.
- GROUPS, BUFFER_NUM/8, number of 8-bank groups written by one 512-bit beat.
- CNT_LEN, 16, width of the beat and tile counters.
- TILE_STRIDE, 9, buffer words per 3x3 kernel tile.
- KER_TIMEOUT, 32, maximum cycles allowed from rd_conf to ker_en.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_start  in  1  pulse; start a load job
- ld_base  in  ADDR_LEN  first buffer row of the load
- ld_beats  in  CNT_LEN  number of 512-bit beats; 0 is legal
- s_data  in  512  weight stream data
- s_valid  in  1  stream valid
- s_ready  out  1  stream ready
- ld_busy  out  1  load job active
- ld_done  out  1  1-cycle pulse at load completion
- data_wr  out  512  to buffer data_wr
- wr_addr  out  ADDR_LEN  to buffer wr_addr
- wr_en  out  BUFFER_NUM  to buffer wr_en
- rd_start  in  1  pulse; start a read job
- rd_base  in  ADDR_LEN  first tile address
- rd_tiles  in  CNT_LEN  number of tiles; 0 is legal
- rd_conf  out  1  to buffer rd_conf
- st_rd_addr  out  ADDR_LEN  to buffer st_rd_addr
- ker_en  in  1  from buffer; tile ready
- tile_valid  out  1  ker_out holds a valid tile
- tile_ready  in  1  mesh has consumed the tile
- rd_busy  out  1  read job active
- rd_done  out  1  1-cycle pulse at read completion
- err_timeout  out  1  sticky; cleared only by rst

Behaviour:
- Reset: every output is 0, both FSMs go idle, all counters are 0. Reset mid-job aborts the job with no done pulse. wr_en is forced to 0 on the reset cycle.
- Load FSM, states L_IDLE and L_RUN:
  - ld_start in L_IDLE latches ld_base and ld_beats. Beats=0 gives ld_done the next cycle and stays in L_IDLE. Otherwise go to L_RUN.
  - ld_start while busy is ignored.
  - s_ready = 1 only in L_RUN. A beat is accepted when s_valid & s_ready.
  - On the cycle after acceptance (registered, latency 1): data_wr = s_data; wr_addr = ld_base + row; wr_en = 8'hFF at bits [g*8 +: 8], all other bits 0. Otherwise wr_en = 0.
  - g increments per beat and wraps GROUPS-1 -> 0. row increments on that wrap.
  - Accepting the last beat returns the FSM to L_IDLE. ld_done pulses in the same cycle as the last wr_en. ld_busy = (state == L_RUN).
  - Address arithmetic is modulo 2^ADDR_LEN and wraps silently.
- Read FSM, states R_IDLE, R_CONF, R_WAIT, R_HOLD:
  - R_IDLE: rd_start latches rd_base and rd_tiles and sets n = 0. Tiles=0 gives rd_done the next cycle. Otherwise go to R_CONF. rd_start while busy is ignored.
  - R_CONF, 1 cycle: rd_conf = 1; st_rd_addr = rd_base + n*TILE_STRIDE, held stable until the next R_CONF. Clear the timeout counter. Go to R_WAIT.
  - R_WAIT: increment the timeout counter.
    - On ker_en: go to R_HOLD with tile_valid = 1 on the next cycle.
    - On counter == KER_TIMEOUT: set err_timeout, abort the job, pulse rd_done, go to R_IDLE.
  - R_HOLD: tile_valid = 1. On tile_ready, n increments. If n was rd_tiles-1, pulse rd_done and go to R_IDLE. Otherwise go to R_CONF.
  - A new rd_conf is never issued while tile_valid is high, because the buffer overwrites ker_out about 10 cycles after rd_conf.
  - rd_busy = (state != R_IDLE).
- The two FSMs are independent and may run concurrently.
- Read/write address overlap is not checked; the upper-level scheduler owns that hazard.
- Simultaneous ld_start and rd_start both start their jobs.

Test Plan:
- Reset, then ld_start, ld_base=0x0010, ld_beats=8, s_valid held 1 -> wr_en sequence 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000 at wr_addr 0x10, then the same four at 0x11; ld_done pulses with the 8th write.
- Load with s_valid toggling 1,0,1,0 -> wr_en only on the cycle after each accepted beat; group sequence and row unchanged by the stalls.
- rd_start, rd_base=0x0100, rd_tiles=3, ker_en returned 12 cycles after each rd_conf, tile_ready high 2 cycles after tile_valid -> exactly 3 rd_conf pulses at st_rd_addr 0x100, 0x109, 0x112; rd_done pulses once; no rd_conf while tile_valid=1.
- Read job with ker_en never asserted -> err_timeout set 32 cycles after rd_conf; rd_done pulses; FSM idle; err_timeout stays 1 until rst.
- ld_beats=0 and rd_tiles=0 started on the same cycle -> ld_done and rd_done pulse the next cycle; no wr_en and no rd_conf.
- rst asserted mid-load (beat 3 of 8) and mid-read (in R_WAIT) -> all outputs 0 on the next cycle; no done pulses; new jobs start normally afterwards.
